fixed_point_reservation_station: RTL and testbench
==================================================

Name: fixed_point_reservation_station

Overview:
- Per-unit reservation station sitting directly downstream of the fixed-point dispatcher; one instance per execution unit (add/sub, mul, div, log, rot, cmp, sys, trap).
- Accepts a dispatched instruction, returns the slot ID it was allocated, holds it until all source operands are available, then issues it to the execution unit.
- Missing operands are captured by snooping the result broadcast bus (tag = producer slot ID).

Parameters:
- RS_ID_WIDTH, 5, width of slot ID / operand tag.
- RS_OFFSET, 0, ID of slot 0; slot i has ID RS_OFFSET+i. Ranges of different instances never overlap.
- RS_DEPTH, 4, number of slots, 1..2^RS_ID_WIDTH-RS_OFFSET.
- OPERANDS, 2, source operands per instruction.
- DATA_WIDTH, 32, operand/result width.
- DECODE_WIDTH, 32, width of the opaque per-unit decode payload.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all slots.
- input_valid  in  1  dispatcher offers an instruction.
- input_ready  out  1  at least one free slot.
- input_decode  in  DECODE_WIDTH  unit decode payload.
- input_op_valid  in  OPERANDS  operand k value already present.
- input_op_value  in  OPERANDS*DATA_WIDTH  operand values (k=0 at MSB end).
- input_op_tag  in  OPERANDS*RS_ID_WIDTH  producer ID for operands not yet valid.
- id_taken  out  RS_ID_WIDTH  ID of the slot the next accepted instruction occupies.
- result_valid  in  1  result broadcast valid.
- result_id  in  RS_ID_WIDTH  producer ID of broadcast.
- result_data  in  DATA_WIDTH  broadcast value.
- output_valid  out  1  a slot is ready to issue.
- output_ready  in  1  execution unit accepts.
- output_decode  out  DECODE_WIDTH  payload of issuing slot.
- output_op_value  out  OPERANDS*DATA_WIDTH  operands of issuing slot.
- output_id  out  RS_ID_WIDTH  ID of issuing slot (becomes result tag).

Behaviour:
- Slot state: busy, decode, per operand {valid, value, tag}.
- Reset (async): all slots not busy, operand valids 0; hence input_ready=1, output_valid=0, id_taken=RS_OFFSET, output_id/decode/op_value=0.
- input_ready = OR of ~busy over slots (state at start of cycle). id_taken = RS_OFFSET + lowest free index; RS_OFFSET when full (don't-care).
- Accept on input_valid & input_ready & ~flush: lowest free slot becomes busy next edge, captures decode, operand valids/values/tags.
- Wake-up: each cycle, every busy slot operand with valid=0 and tag==result_id while result_valid latches result_data, valid=1.
- Same-cycle bypass: an operand being written with input_op_valid=0 and input_op_tag==result_id while result_valid is stored valid with result_data.
- Issue select: lowest-index busy slot with all operands valid; output_valid/decode/op_value/id combinational from slot registers. Operand woken this cycle is eligible next cycle (one-cycle wakeup latency; min accept-to-issue latency 1 cycle).
- Handshake: output fields stable while output_valid & ~output_ready unless a lower-index slot becomes ready (selection may change; unit must sample only on handshake).
- On output_valid & output_ready: slot freed at next edge; slot not reusable in same cycle (input_ready does not count it).
- Simultaneous accept and issue: different slots, both happen.
- Full: input_ready=0; input_valid ignored, no state change.
- flush: all slots freed next edge, overrides accept/wake-up; issue handshake in flush cycle still valid for the unit.
- rst mid-operation: all contents discarded immediately.
- Broadcast with unmatched tag: no effect.

Test Plan:
- RS_OFFSET=8: reset -> input_ready=1, id_taken=8, output_valid=0; accept ops {5,7} both valid -> next cycle output_valid=1, output_id=8, ops {5,7}.
- Accept op0 valid=0 tag=3; 2 cycles later result_valid id=3 data=0x1234 -> output_valid=1 the cycle after, op0=0x1234; broadcast id=4 beforehand -> no wake.
- Accept with op1 tag=3 in same cycle as broadcast id=3 data=0xAA -> issues next cycle with op1=0xAA.
- RS_DEPTH=4, output_ready=0: 4 accepts -> id_taken 8,9,10,11, then input_ready=0; one issue handshake -> input_ready=1 next cycle, id_taken=slot freed.
- Slots 0 and 2 ready, output_ready=1 -> slot 0 (ID 8) issues first, slot 2 (ID 10) next cycle.
- Two slots busy, flush=1 with input_valid=1 -> next cycle input_ready=1, id_taken=8, output_valid=0, new instruction not captured.

Source files
------------

// File: rtl/fixed_point_reservation_station_if.sv
// Dispatch, result broadcast and issue signals of one reservation station.
interface fixed_point_reservation_station_if #(
  parameter int RS_ID_WIDTH  = 5,
  parameter int OPERANDS     = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int DECODE_WIDTH = 32
);
  logic                             input_valid;
  logic                             input_ready;
  logic [DECODE_WIDTH-1:0]          input_decode;
  logic [OPERANDS-1:0]              input_op_valid;
  logic [OPERANDS*DATA_WIDTH-1:0]   input_op_value;
  logic [OPERANDS*RS_ID_WIDTH-1:0]  input_op_tag;
  logic [RS_ID_WIDTH-1:0]           id_taken;
  logic                             result_valid;
  logic [RS_ID_WIDTH-1:0]           result_id;
  logic [DATA_WIDTH-1:0]            result_data;
  logic                             output_valid;
  logic                             output_ready;
  logic [DECODE_WIDTH-1:0]          output_decode;
  logic [OPERANDS*DATA_WIDTH-1:0]   output_op_value;
  logic [RS_ID_WIDTH-1:0]           output_id;

  modport master (
    output input_valid, input_decode, input_op_valid, input_op_value, input_op_tag,
           result_valid, result_id, result_data, output_ready,
    input  input_ready, id_taken, output_valid, output_decode, output_op_value, output_id
  );

  modport slave (
    input  input_valid, input_decode, input_op_valid, input_op_value, input_op_tag,
           result_valid, result_id, result_data, output_ready,
    output input_ready, id_taken, output_valid, output_decode, output_op_value, output_id
  );
endinterface

// File: rtl/fixed_point_reservation_station.sv
// Per-unit reservation station: holds dispatched instructions until every
// source operand is present (directly or via result broadcast), then issues
// the lowest-index ready slot to the execution unit.
module fixed_point_reservation_station #(
  parameter int RS_ID_WIDTH  = 5,
  parameter int RS_OFFSET    = 0,
  parameter int RS_DEPTH     = 4,
  parameter int OPERANDS     = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int DECODE_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic flush,
  fixed_point_reservation_station_if.slave bus
);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam logic [RS_ID_WIDTH-1:0] ID_BASE = RS_ID_WIDTH'(RS_OFFSET);

  logic                    busy       [RS_DEPTH];
  logic [DECODE_WIDTH-1:0] decode_q   [RS_DEPTH];
  logic                    op_valid_q [RS_DEPTH][OPERANDS];
  logic [DATA_WIDTH-1:0]   op_value_q [RS_DEPTH][OPERANDS];
  logic [RS_ID_WIDTH-1:0]  op_tag_q   [RS_DEPTH][OPERANDS];

  logic             slot_ready [RS_DEPTH];
  logic             any_free;
  logic             any_ready;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] issue_idx;
  logic             accept;
  logic             issue;

  // A slot may issue once it is busy and all its operands are captured.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      slot_ready[i] = busy[i];
      for (int k = 0; k < OPERANDS; k++) slot_ready[i] = slot_ready[i] & op_valid_q[i][k];
    end
  end

  // Priority encoders: lowest free slot for allocation, lowest ready slot for issue.
  always_comb begin
    any_free  = 1'b0;
    free_idx  = '0;
    any_ready = 1'b0;
    issue_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (slot_ready[i]) begin
        any_ready = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  assign accept           = bus.input_valid & any_free & ~flush;
  assign issue            = any_ready & bus.output_ready;
  assign bus.input_ready  = any_free;
  assign bus.id_taken     = ID_BASE + RS_ID_WIDTH'(free_idx);
  assign bus.output_valid = any_ready;

  // Issue fields come straight from the selected slot; zero while nothing is ready.
  always_comb begin
    bus.output_decode   = '0;
    bus.output_op_value = '0;
    bus.output_id       = '0;
    if (any_ready) begin
      bus.output_decode = decode_q[issue_idx];
      bus.output_id     = ID_BASE + RS_ID_WIDTH'(issue_idx);
      for (int k = 0; k < OPERANDS; k++)
        bus.output_op_value[(OPERANDS-1-k)*DATA_WIDTH +: DATA_WIDTH] = op_value_q[issue_idx][k];
    end
  end

  // Slot state: flush beats everything; otherwise wake-up, issue free and allocation.
  // The allocated slot is free at the start of the cycle, so it never collides with
  // the issuing slot, and its operand capture includes a same-cycle broadcast bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        busy[i]     <= 1'b0;
        decode_q[i] <= '0;
        for (int k = 0; k < OPERANDS; k++) begin
          op_valid_q[i][k] <= 1'b0;
          op_value_q[i][k] <= '0;
          op_tag_q[i][k]   <= '0;
        end
      end
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        busy[i] <= 1'b0;
        for (int k = 0; k < OPERANDS; k++) op_valid_q[i][k] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        for (int k = 0; k < OPERANDS; k++) begin
          if (bus.result_valid && busy[i] && !op_valid_q[i][k] &&
              op_tag_q[i][k] == bus.result_id) begin
            op_valid_q[i][k] <= 1'b1;
            op_value_q[i][k] <= bus.result_data;
          end
        end
        if (issue && IDX_W'(i) == issue_idx) busy[i] <= 1'b0;
        if (accept && IDX_W'(i) == free_idx) begin
          busy[i]     <= 1'b1;
          decode_q[i] <= bus.input_decode;
          for (int k = 0; k < OPERANDS; k++) begin
            op_tag_q[i][k] <= bus.input_op_tag[(OPERANDS-1-k)*RS_ID_WIDTH +: RS_ID_WIDTH];
            if (bus.input_op_valid[OPERANDS-1-k]) begin
              op_valid_q[i][k] <= 1'b1;
              op_value_q[i][k] <= bus.input_op_value[(OPERANDS-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end else if (bus.result_valid &&
                         bus.input_op_tag[(OPERANDS-1-k)*RS_ID_WIDTH +: RS_ID_WIDTH] == bus.result_id) begin
              op_valid_q[i][k] <= 1'b1;
              op_value_q[i][k] <= bus.result_data;
            end else begin
              op_valid_q[i][k] <= 1'b0;
              op_value_q[i][k] <= bus.input_op_value[(OPERANDS-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_reservation_station.sv
// Bench for fixed_point_reservation_station (RS_OFFSET=8, depth 4, two operands).
// Expected issues are queued as instructions are dispatched and compared on
// every output handshake; status outputs are checked directly along the way.
module tb_fixed_point_reservation_station;
  localparam int W  = 5;
  localparam int DW = 32;

  typedef struct {
    logic [W-1:0]    id;
    logic [31:0]     dec;
    logic [2*DW-1:0] ops;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  fixed_point_reservation_station_if #(.RS_ID_WIDTH(W), .OPERANDS(2), .DATA_WIDTH(DW),
                                       .DECODE_WIDTH(32)) bus ();

  fixed_point_reservation_station #(.RS_ID_WIDTH(W), .RS_OFFSET(8), .RS_DEPTH(4),
                                    .OPERANDS(2), .DATA_WIDTH(DW), .DECODE_WIDTH(32))
    dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: every issue must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.output_valid && bus.output_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_issue", 128'(sb.size()), 128'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_id", 128'(bus.output_id), 128'(e.id));
        check("issue_decode", 128'(bus.output_decode), 128'(e.dec));
        check("issue_ops", 128'(bus.output_op_value), 128'(e.ops));
      end
    end
  end

  task automatic idle();
    bus.input_valid    = 1'b0;
    bus.input_decode   = '0;
    bus.input_op_valid = '0;
    bus.input_op_value = '0;
    bus.input_op_tag   = '0;
    bus.result_valid   = 1'b0;
    bus.result_id      = '0;
    bus.result_data    = '0;
    flush              = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic drive_in(input logic [31:0] dec,
                          input logic v0, input logic [31:0] d0, input logic [W-1:0] t0,
                          input logic v1, input logic [31:0] d1, input logic [W-1:0] t1);
    bus.input_valid    = 1'b1;
    bus.input_decode   = dec;
    bus.input_op_valid = {v0, v1};
    bus.input_op_value = {d0, d1};
    bus.input_op_tag   = {t0, t1};
  endtask

  task automatic broadcast(input logic [W-1:0] id, input logic [31:0] data);
    bus.result_valid = 1'b1;
    bus.result_id    = id;
    bus.result_data  = data;
  endtask

  task automatic expect_issue(input int id, input logic [31:0] dec,
                              input logic [31:0] o0, input logic [31:0] o1);
    exp_t e;
    e.id  = W'(id);
    e.dec = dec;
    e.ops = {o0, o1};
    sb.push_back(e);
  endtask

  initial begin
    idle();
    bus.output_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    check("rst_input_ready", 128'(bus.input_ready), 128'd1);
    check("rst_id_taken", 128'(bus.id_taken), 128'd8);
    check("rst_output_valid", 128'(bus.output_valid), 128'd0);
    check("rst_output_id", 128'(bus.output_id), 128'd0);
    check("rst_output_decode", 128'(bus.output_decode), 128'd0);

    // Both operands present: issue the next cycle
    drive_in(32'h11, 1, 32'd5, 0, 1, 32'd7, 0);
    expect_issue(8, 32'h11, 32'd5, 32'd7);
    cyc();
    check("direct_valid", 128'(bus.output_valid), 128'd1);
    check("direct_id", 128'(bus.output_id), 128'd8);
    check("direct_ops", 128'(bus.output_op_value), {64'd0, 32'd5, 32'd7});
    bus.output_ready = 1'b1;
    cyc();
    bus.output_ready = 1'b0;
    check("after_issue_valid", 128'(bus.output_valid), 128'd0);
    check("after_issue_ready", 128'(bus.input_ready), 128'd1);

    // Operand 0 waits for tag 3; a tag-4 broadcast must not wake it
    drive_in(32'h22, 0, 32'd0, 5'd3, 1, 32'd9, 0);
    cyc();
    check("wait_valid0", 128'(bus.output_valid), 128'd0);
    cyc();
    broadcast(5'd4, 32'hdead);
    cyc();
    check("nomatch_valid", 128'(bus.output_valid), 128'd0);
    broadcast(5'd3, 32'h1234);
    cyc();
    check("wake_valid", 128'(bus.output_valid), 128'd1);
    expect_issue(8, 32'h22, 32'h1234, 32'd9);
    bus.output_ready = 1'b1;
    cyc();
    bus.output_ready = 1'b0;

    // Same-cycle bypass on operand 1
    drive_in(32'h33, 1, 32'd1, 0, 0, 32'd0, 5'd3);
    broadcast(5'd3, 32'hAA);
    cyc();
    check("bypass_valid", 128'(bus.output_valid), 128'd1);
    expect_issue(8, 32'h33, 32'd1, 32'hAA);
    bus.output_ready = 1'b1;
    cyc();
    bus.output_ready = 1'b0;

    // Fill all four slots, then free one
    for (int i = 0; i < 4; i++) begin
      check("fill_id_taken", 128'(bus.id_taken), 128'(8 + i));
      drive_in(32'h40 + 32'(i), 1, 32'(i), 0, 1, 32'(i + 100), 0);
      expect_issue(8 + i, 32'h40 + 32'(i), 32'(i), 32'(i + 100));
      cyc();
    end
    check("full_input_ready", 128'(bus.input_ready), 128'd0);
    drive_in(32'h99, 1, 32'd9, 0, 1, 32'd9, 0);
    cyc();
    check("full_ignored_ready", 128'(bus.input_ready), 128'd0);
    bus.output_ready = 1'b1;
    cyc();
    bus.output_ready = 1'b0;
    check("freed_input_ready", 128'(bus.input_ready), 128'd1);
    check("freed_id_taken", 128'(bus.id_taken), 128'd8);
    bus.output_ready = 1'b1;
    repeat (3) cyc();
    bus.output_ready = 1'b0;
    check("drained_valid", 128'(bus.output_valid), 128'd0);

    // Issue priority: slots 0 and 2 ready, slot 0 first
    drive_in(32'h51, 0, 32'd0, 5'd20, 1, 32'd1, 0);
    cyc();
    drive_in(32'h52, 0, 32'd0, 5'd21, 1, 32'd2, 0);
    cyc();
    drive_in(32'h53, 1, 32'd3, 0, 1, 32'd4, 0);
    cyc();
    check("prio_only2_id", 128'(bus.output_id), 128'd10);
    broadcast(5'd20, 32'h50);
    cyc();
    check("prio_first_id", 128'(bus.output_id), 128'd8);
    expect_issue(8, 32'h51, 32'h50, 32'd1);
    expect_issue(10, 32'h53, 32'd3, 32'd4);
    bus.output_ready = 1'b1;
    cyc();
    check("prio_second_id", 128'(bus.output_id), 128'd10);
    cyc();
    bus.output_ready = 1'b0;
    check("prio_b_waiting", 128'(bus.output_valid), 128'd0);
    broadcast(5'd21, 32'h60);
    cyc();
    expect_issue(9, 32'h52, 32'h60, 32'd2);
    bus.output_ready = 1'b1;
    cyc();
    bus.output_ready = 1'b0;

    // Flush with a concurrent dispatch
    drive_in(32'h61, 0, 32'd0, 5'd25, 1, 32'd0, 0);
    cyc();
    drive_in(32'h62, 0, 32'd0, 5'd26, 1, 32'd0, 0);
    cyc();
    check("preflush_id_taken", 128'(bus.id_taken), 128'd10);
    flush = 1'b1;
    drive_in(32'h63, 1, 32'd1, 0, 1, 32'd1, 0);
    cyc();
    check("flush_input_ready", 128'(bus.input_ready), 128'd1);
    check("flush_id_taken", 128'(bus.id_taken), 128'd8);
    check("flush_output_valid", 128'(bus.output_valid), 128'd0);
    broadcast(5'd25, 32'h77);
    cyc();
    cyc();
    check("flush_no_wake", 128'(bus.output_valid), 128'd0);

    // Asynchronous reset discards a ready slot immediately
    drive_in(32'h71, 1, 32'd1, 0, 1, 32'd1, 0);
    cyc();
    check("prerst_valid", 128'(bus.output_valid), 128'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(bus.output_valid), 128'd0);
    check("async_rst_ready", 128'(bus.input_ready), 128'd1);
    #2 rst = 1'b0;
    cyc();
    check("post_rst_valid", 128'(bus.output_valid), 128'd0);

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
